// File: rtl/dp_ctrl_fsm.sv
// Multi-cycle control unit for the ARM data-processing datapath: handshake fetch with timeout,
// condition evaluation, DP0/DP1/DP2 decode and FETCH->CHECK->DECODE->EXEC->WB sequencing.
module dp_ctrl_fsm #(
   parameter int PC_W    = 6,
   parameter int PC_STEP = 1,
   parameter int TIMEOUT = 15
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_fetch_ack,
   input  logic [31:0]     i_fetch_data,
   input  logic [3:0]      i_nzcv,
   output logic            o_fetch_req,
   output logic [PC_W-1:0] o_pc,
   output logic [31:0]     o_ir,
   output logic            o_la,
   output logic            o_lb,
   output logic            o_lc,
   output logic            o_lf,
   output logic            o_s_en,
   output logic            o_write_reg,
   output logic            o_rm_imm_s,
   output logic [1:0]      o_rs_imm_s,
   output logic [3:0]      o_alu_op,
   output logic [2:0]      o_shift_op,
   output logic            o_und_trap,
   output logic            o_timeout_err,
   output logic            o_busy
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_CHECK  = 3'd2,
      S_TRAP   = 3'd3,
      S_DECODE = 3'd4,
      S_EXEC   = 3'd5,
      S_WB     = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   // Format code doubles as the shift-amount select value for the three legal formats.
   typedef enum logic [1:0] {
      F_DP0 = 2'd0,
      F_DP1 = 2'd1,
      F_DP2 = 2'd2,
      F_UND = 2'd3
   } fmt_t;

   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
      logic n, z, c, v, ok;
      {n, z, c, v} = flags;
      case (cond)
         4'h0:    ok = z;
         4'h1:    ok = ~z;
         4'h2:    ok = c;
         4'h3:    ok = ~c;
         4'h4:    ok = n;
         4'h5:    ok = ~n;
         4'h6:    ok = v;
         4'h7:    ok = ~v;
         4'h8:    ok = c & ~z;
         4'h9:    ok = ~c | z;
         4'hA:    ok = (n == v);
         4'hB:    ok = (n != v);
         4'hC:    ok = ~z & (n == v);
         4'hD:    ok = z | (n != v);
         4'hE:    ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic fmt_t decode_fmt(input logic [31:0] ir);
      fmt_t f;
      if (ir[15:12] == 4'hF) begin
         f = F_UND;
      end else begin
         case (ir[27:25])
            3'b000:  f = ir[4] ? (ir[7] ? F_UND : F_DP1) : F_DP0;
            3'b001:  f = F_DP2;
            default: f = F_UND;
         endcase
      end
      return f;
   endfunction

   state_t            r_state;
   state_t            w_state_nxt;
   logic [PC_W-1:0]   r_pc;
   logic [31:0]       r_ir;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              w_accept;
   logic              w_timeout_hit;
   logic              w_cond_ok;
   fmt_t              w_fmt;
   logic              w_sel_hold;
   logic [3:0]        w_alu_op;
   logic [2:0]        w_shift_op;

   logic r_fetch_req, r_la, r_lb, r_lc, r_lf, r_s_en, r_write_reg;
   logic r_rm_imm_s, r_und_trap, r_timeout_err, r_busy;
   logic [1:0] r_rs_imm_s;

   assign w_fmt         = decode_fmt(r_ir);
   assign w_cond_ok     = cond_pass(r_ir[31:28], i_nzcv);
   assign w_cnt_inc     = r_cnt + CNT_W'(1);
   assign w_accept      = (r_state == S_FETCH) && i_fetch_ack;
   assign w_timeout_hit = (TIMEOUT != 0) && (w_cnt_inc == CNT_W'(TIMEOUT));
   assign w_sel_hold    = (w_state_nxt == S_EXEC) || (w_state_nxt == S_WB);

   // Next-state logic; an ack in the last allowed wait cycle is accepted rather than timed out.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: w_state_nxt = S_FETCH;
         S_FETCH: begin
            if (i_fetch_ack) begin
               w_state_nxt = S_CHECK;
            end else if (w_timeout_hit) begin
               w_state_nxt = S_ERR;
            end else begin
               w_state_nxt = S_FETCH;
            end
         end
         S_CHECK: begin
            if (!w_cond_ok) begin
               w_state_nxt = S_FETCH;
            end else if (w_fmt == F_UND) begin
               w_state_nxt = S_TRAP;
            end else begin
               w_state_nxt = S_DECODE;
            end
         end
         S_TRAP:   w_state_nxt = S_FETCH;
         S_DECODE: w_state_nxt = S_EXEC;
         S_EXEC:   w_state_nxt = S_WB;
         S_WB:     w_state_nxt = S_FETCH;
         S_ERR:    w_state_nxt = S_ERR;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // State, program counter, instruction register and fetch wait counter.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
         r_ir    <= 32'h0000_0000;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_ir <= i_fetch_data;
            r_pc <= r_pc + PC_W'(PC_STEP);
         end else begin
            r_ir <= r_ir;
            r_pc <= r_pc;
         end
         if ((r_state == S_FETCH) && !i_fetch_ack) begin
            r_cnt <= w_cnt_inc;
         end else begin
            r_cnt <= '0;
         end
      end
   end

   // Strobes are registered from the next state, so each is high exactly while in its state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_fetch_req   <= 1'b0;
         r_la          <= 1'b0;
         r_lb          <= 1'b0;
         r_lc          <= 1'b0;
         r_lf          <= 1'b0;
         r_s_en        <= 1'b0;
         r_write_reg   <= 1'b0;
         r_rm_imm_s    <= 1'b0;
         r_rs_imm_s    <= 2'd0;
         r_und_trap    <= 1'b0;
         r_timeout_err <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_fetch_req   <= (w_state_nxt == S_FETCH);
         r_la          <= (w_state_nxt == S_DECODE);
         r_lb          <= (w_state_nxt == S_DECODE);
         r_lc          <= (w_state_nxt == S_DECODE);
         r_lf          <= (w_state_nxt == S_EXEC);
         r_s_en        <= (w_state_nxt == S_EXEC) && r_ir[20];
         r_write_reg   <= (w_state_nxt == S_WB) && (r_ir[24:23] != 2'b10);
         r_rm_imm_s    <= w_sel_hold && (w_fmt == F_DP2);
         r_rs_imm_s    <= w_sel_hold ? 2'(w_fmt) : 2'd0;
         r_und_trap    <= (w_state_nxt == S_TRAP);
         r_timeout_err <= (w_state_nxt == S_ERR);
         r_busy        <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_ERR);
      end
   end

   // Compare/test opcodes are remapped onto the plain ALU ops they perform.
   always_comb begin
      w_alu_op = r_ir[24:21];
      if (r_ir[24:23] == 2'b10) begin
         case (r_ir[22:21])
            2'b00:   w_alu_op = 4'b0000;
            2'b01:   w_alu_op = 4'b0001;
            2'b10:   w_alu_op = 4'b0010;
            2'b11:   w_alu_op = 4'b0100;
            default: w_alu_op = 4'b0000;
         endcase
      end else begin
         w_alu_op = r_ir[24:21];
      end
   end

   // Shifter opcode: rotate-immediate for DP2, otherwise shift type plus register-amount flag.
   always_comb begin
      w_shift_op = 3'b000;
      if (w_fmt == F_DP2) begin
         w_shift_op = 3'b111;
      end else begin
         w_shift_op = {r_ir[6:5], (w_fmt == F_DP1)};
      end
   end

   assign o_fetch_req   = r_fetch_req;
   assign o_pc          = r_pc;
   assign o_ir          = r_ir;
   assign o_la          = r_la;
   assign o_lb          = r_lb;
   assign o_lc          = r_lc;
   assign o_lf          = r_lf;
   assign o_s_en        = r_s_en;
   assign o_write_reg   = r_write_reg;
   assign o_rm_imm_s    = r_rm_imm_s;
   assign o_rs_imm_s    = r_rs_imm_s;
   assign o_alu_op      = w_alu_op;
   assign o_shift_op    = w_shift_op;
   assign o_und_trap    = r_und_trap;
   assign o_timeout_err = r_timeout_err;
   assign o_busy        = r_busy;

endmodule
